// File: rtl/alu32_pkg.sv
// ---------------------------------------------------------------------------
// alu32_pkg : constants and types shared by the ALU32 units and checker
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu32_pkg;

  localparam int          ALU32_WIDTH = 32;
  localparam logic [31:0] DEF_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SEED    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/misr32.sv
// ---------------------------------------------------------------------------
// misr32 : combinational next-signature step (shift, polynomial feedback, xor)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module misr32
  import alu32_pkg::*;
#(
  parameter int          WIDTH = ALU32_WIDTH,
  parameter logic [WIDTH-1:0] POLY = DEF_POLY
) (
  input  logic [WIDTH-1:0] sig_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] w_fb;

  assign w_fb   = sig_i[WIDTH-1] ? POLY : '0;
  assign next_o = {sig_i[WIDTH-2:0], 1'b0} ^ w_fb ^ data_i;

endmodule

`default_nettype wire

// File: rtl/alu32_resp_checker.sv
// ---------------------------------------------------------------------------
// alu32_resp_checker : compacts a result-word stream into a MISR signature and
//                      reports pass/fail against an expected signature
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu32_resp_checker
  import alu32_pkg::*;
#(
  parameter int               WIDTH = ALU32_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = DEF_POLY,
  parameter logic [WIDTH-1:0] SEED  = DEF_SEED,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic [WIDTH-1:0] exp_sig,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] word_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;

  logic [WIDTH-1:0] w_sig_next;
  logic [CNT_W-1:0] w_cnt_inc;

  misr32 #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .sig_i  (sig_q),
    .data_i (in_data),
    .next_o (w_sig_next)
  );

  assign w_cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = num_words;
          exp_d   = exp_sig;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = (num_words == '0) ? ST_CHECK : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          sig_d = w_sig_next;
          cnt_d = w_cnt_inc;
          // The count that just completed the run is compared, so no wrap occurs
          if (w_cnt_inc == num_q) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        done_d  = 1'b1;
        pass_d  = (sig_q == exp_q);
        fail_d  = (sig_q != exp_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      exp_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign signature = sig_q;
  assign word_cnt  = cnt_q;

endmodule

`default_nettype wire
